// File: rtl/mem_if_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_if_pkg : shared widths, FSM state type and helpers for ext_mem_wait  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_if_pkg;

  localparam int MEM_WORD_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A zero-wait build still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ext_mem_wait_be_ram.sv
// +--------------------------------------------------------------------------+
// | be_ram : single-port word RAM, byte-masked write, registered read        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module be_ram
  import mem_if_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [MEM_BE_W-1:0]      i_be,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [MEM_WORD_W-1:0]    i_wd,
  output logic [MEM_WORD_W-1:0]    o_rd
);

  logic [MEM_WORD_W-1:0] r_mem [DEPTH];
  logic [MEM_WORD_W-1:0] r_rd;

  always_ff @(posedge clk_i) begin
    if (i_en && i_we) begin
      for (int n = 0; n < MEM_BE_W; n++) begin
        if (i_be[n]) begin
          r_mem[i_idx][8*n +: 8] <= i_wd[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_en) begin
      r_rd <= i_we ? '0 : r_mem[i_idx];
    end
  end

  assign o_rd = r_rd;

endmodule

`default_nettype wire

// File: rtl/ext_mem_wait.sv
// +--------------------------------------------------------------------------+
// | ext_mem_wait : LSU data-memory responder with programmable wait states   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module ext_mem_wait
  import mem_if_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_i,
  input  logic                  write_enable_i,
  input  logic [MEM_BE_W-1:0]   byte_enable_i,
  input  logic [31:0]           addr_i,
  input  logic [MEM_WORD_W-1:0] write_data_i,
  output logic [MEM_WORD_W-1:0] read_data_o,
  output logic                  ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(WAIT_CYCLES);

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [MEM_BE_W-1:0]   r_be;
  logic [AW-1:0]         r_idx;
  logic [MEM_WORD_W-1:0] r_wd;
  logic                  r_in_range;

  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_ready;
  logic                  w_rd_valid;
  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [MEM_BE_W-1:0]   w_ram_be;
  logic [AW-1:0]         w_ram_idx;
  logic [MEM_WORD_W-1:0] w_ram_wd;
  logic [MEM_WORD_W-1:0] w_ram_rd;
  logic [1:0]            w_unused_addr;

  assign w_unused_addr = addr_i[1:0];
  assign w_in_range    = (addr_i[31:AW+2] == '0);
  assign w_accept      = (r_state == ST_IDLE) && mem_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // In IDLE the zero-wait access uses the live request; otherwise the latched copy.
  always_comb begin
    w_ready   = 1'b0;
    w_ram_en  = 1'b0;
    w_ram_we  = r_we;
    w_ram_be  = r_be;
    w_ram_idx = r_idx;
    w_ram_wd  = r_wd;
    case (r_state)
      ST_IDLE: begin
        w_ram_we  = write_enable_i;
        w_ram_be  = byte_enable_i;
        w_ram_idx = addr_i[AW+1:2];
        w_ram_wd  = write_data_i;
        if (mem_req_i && (WAIT_CYCLES == 0)) begin
          w_ram_en = w_in_range;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_ram_en = r_in_range;
        end
      end
      ST_RESP: w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
    // A reset held across the perform edge must drop the access.
    if (rst_i) begin
      w_ram_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_be       <= '0;
      r_idx      <= '0;
      r_wd       <= '0;
      r_in_range <= 1'b0;
    end else if (w_accept) begin
      r_we       <= write_enable_i;
      r_be       <= byte_enable_i;
      r_idx      <= addr_i[AW+1:2];
      r_wd       <= write_data_i;
      r_in_range <= w_in_range;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);
    end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  be_ram #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i (clk_i),
    .i_en  (w_ram_en),
    .i_we  (w_ram_we),
    .i_be  (w_ram_be),
    .i_idx (w_ram_idx),
    .i_wd  (w_ram_wd),
    .o_rd  (w_ram_rd)
  );

  assign w_rd_valid  = w_ready && r_in_range && !r_we;
  assign ready_o     = w_ready;
  assign read_data_o = w_rd_valid ? w_ram_rd : '0;

endmodule

`default_nettype wire

// File: tb/tb_ext_mem_wait.sv
// +--------------------------------------------------------------------------+
// | tb_ext_mem_wait : self-checking bench, WAIT_CYCLES=2 and =0 instances    |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ext_mem_wait;

  localparam int DEPTH = 1024;
  localparam int WAITS [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  ext_mem_wait #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .write_enable_i(we[0]),
    .byte_enable_i(be[0]), .addr_i(addr[0]), .write_data_i(wd[0]),
    .read_data_o(rdata[0]), .ready_o(rdy[0])
  );

  ext_mem_wait #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .write_enable_i(we[1]),
    .byte_enable_i(be[1]), .addr_i(addr[1]), .write_data_i(wd[1]),
    .read_data_o(rdata[1]), .ready_o(rdy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory: any address at or beyond DEPTH words reads zero and absorbs writes.
  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    int key;
    if (a >= 32'(DEPTH * 4)) return 32'h0;
    key = (d << 20) | int'(a >> 2);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  task automatic model_write(input int d, input logic [3:0] b, input logic [31:0] a,
                             input logic [31:0] data);
    int key;
    logic [31:0] w;
    if (a >= 32'(DEPTH * 4)) return;
    key = (d << 20) | int'(a >> 2);
    w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    for (int n = 0; n < 4; n++) if (b[n]) w[8*n +: 8] = data[8*n +: 8];
    ref_mem[key] = w;
  endtask

  task automatic txn(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] data, output logic [31:0] rd, output int lat);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wd[d] = data;
    @(posedge clk); #1;
    lat = 1;
    while (!rdy[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata[d];
    req[d] = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(rdy[d]), 32'h0);
  endtask

  task automatic txn_check(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                           input logic [31:0] data, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    int lat;
    txn(d, w, b, a, data, rd, lat);
    chk({nm, "_latency"}, 32'(lat), 32'(WAITS[d] + 1));
    chk({nm, "_data"}, rd, exp);
    if (w) model_write(d, b, a, data);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int pulses, first;
    logic [31:0] a, data;
    logic [3:0] b;
    logic w;

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wd[d] = '0;
    end

    vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h14,       32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 4'h5, 32'h14,       32'hAABBCCDD, 32'h0};
    vecs[4]  = '{1'b0, 4'hF, 32'h14,       32'h0,        32'h11BB33DD};
    vecs[5]  = '{1'b1, 4'hF, 32'h0,        32'h0BADF00D, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, 32'h1000,     32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{1'b0, 4'hF, 32'h1000,     32'h0,        32'h0};
    vecs[8]  = '{1'b0, 4'hF, 32'h0,        32'h0,        32'h0BADF00D};
    vecs[9]  = '{1'b1, 4'h0, 32'h14,       32'h00000000, 32'h0};
    vecs[10] = '{1'b0, 4'hF, 32'h14,       32'h0,        32'h11BB33DD};
    vecs[11] = '{1'b0, 4'hF, 32'h80000010, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 4'h8, 32'h13,       32'h55667788, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(rdy[d]), 32'h0);
      chk("reset_rdata", rdata[d], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      txn_check(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, vecs[i].exp, "vec");
    end
    txn_check(0, 1'b0, 4'hF, 32'h12, 32'h0, 32'h55ADBEEF, "low_addr_bits");

    // Zero-wait instance: request held high gives pulses separated by one idle cycle.
    txn_check(1, 1'b1, 4'hF, 32'h0, 32'h01010101, 32'h0, "b_wr0");
    txn_check(1, 1'b1, 4'hF, 32'h4, 32'h02020202, 32'h0, "b_wr4");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
    @(posedge clk); #1;
    chk("b2b_ready0", 32'(rdy[1]), 32'h1);
    chk("b2b_data0", rdata[1], 32'h01010101);
    addr[1] = 32'h4;
    @(posedge clk); #1;
    chk("b2b_gap", 32'(rdy[1]), 32'h0);
    chk("b2b_gap_data", rdata[1], 32'h0);
    @(posedge clk); #1;
    chk("b2b_ready1", 32'(rdy[1]), 32'h1);
    chk("b2b_data1", rdata[1], 32'h02020202);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", 32'(rdy[1]), 32'h0);

    // Request withdrawn right after acceptance still completes exactly once.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10;
    @(posedge clk); #1;
    req[0] = 1'b0;
    pulses = 0; first = 0;
    for (int c = 1; c <= 8; c++) begin
      if (rdy[0]) begin
        pulses++;
        if (first == 0) first = c;
        chk("drop_data", rdata[0], model_read(0, 32'h10));
      end
      @(posedge clk); #1;
    end
    chk("drop_pulses", 32'(pulses), 32'h1);
    chk("drop_latency", 32'(first), 32'h3);

    // Reset landing in WAIT cancels the pending write.
    txn_check(0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 32'h0, "pre_wr20");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h20; wd[0] = 32'h12345678;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_wait_ready", 32'(rdy[0]), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn_check(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hCAFEF00D, "rst_wr_dropped");
    txn_check(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h55ADBEEF, "rst_survive");

    // Reset during RESP clears the outputs immediately.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("resp_ready", 32'(rdy[0]), 32'h1);
    chk("resp_data", rdata[0], 32'h55ADBEEF);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_resp_ready", 32'(rdy[0]), 32'h0);
    chk("rst_resp_data", rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic on a small word pool plus out-of-range accesses.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) begin
        txn_check(d, 1'b1, 4'hF, 32'h200 + 32'(k * 4), $urandom, 32'h0, "pool_init");
      end
      for (int k = 0; k < 60; k++) begin
        w = 1'($urandom_range(0, 1));
        b = 4'($urandom);
        data = $urandom;
        if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
        else a = 32'h200 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        txn_check(d, w, b, a, data, w ? 32'h0 : model_read(d, a), "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
